mem_arbiter: RTL

Two-requester arbiter and sequencer for the core's single-ported program/data memory (combinational read, synchronous write, word-addressed through addr[31:2]). It shares that one port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It keeps at most one transaction outstanding, registers the read data, and returns it over a valid/ready response handshake.

---
 rtl/mem_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch and load/store.
// One transaction in flight at a time; read data is registered and returned over valid/ready.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_rsp_valid,
  input  logic                  ifu_rsp_ready,
  output logic [DATA_W-1:0]     ifu_rdata,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wmask,
  output logic                  lsu_rsp_valid,
  input  logic                  lsu_rsp_ready,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t              state_reg;
  logic                owner_reg;       // 1 = LSU owns the outstanding response
  logic                last_grant_reg;  // 1 = LSU was granted most recently
  logic [DATA_W-1:0]   rdata_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;

  logic grant_lsu;
  logic accept;
  logic store_accept;
  logic owner_rsp_ready;

  // On a tie the LSU wins unless it was the last one served.
  always_comb begin
    grant_lsu       = lsu_req_valid && (!ifu_req_valid || !last_grant_reg);
    accept          = (state_reg == IDLE) && (ifu_req_valid || lsu_req_valid) && !rst;
    store_accept    = accept && grant_lsu && lsu_wen;
    owner_rsp_ready = owner_reg ? lsu_rsp_ready : ifu_rsp_ready;
  end

  assign ifu_req_ready = accept && !grant_lsu;
  assign lsu_req_ready = accept && grant_lsu;

  // Address follows the winner during accept and otherwise holds its last value.
  assign mem_addr  = accept ? (grant_lsu ? lsu_addr : ifu_addr) : mem_addr_reg;
  assign mem_wen   = store_accept;
  assign mem_wdata = store_accept ? lsu_wdata : '0;
  assign mem_wmask = store_accept ? lsu_wmask : '0;

  assign ifu_rsp_valid = (state_reg == RESP) && !owner_reg;
  assign lsu_rsp_valid = (state_reg == RESP) && owner_reg;
  assign ifu_rdata     = owner_reg ? '0 : rdata_reg;
  assign lsu_rdata     = owner_reg ? rdata_reg : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b0;
      rdata_reg      <= '0;
      mem_addr_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            rdata_reg      <= store_accept ? '0 : mem_rdata;
            owner_reg      <= grant_lsu;
            last_grant_reg <= grant_lsu;
            mem_addr_reg   <= mem_addr;
            state_reg      <= RESP;
          end
        end
        RESP: begin
          if (owner_rsp_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
